misr_bist_ctrl: RTL and testbench

BIST sequencer for the 10-bit MISR signature compactor. It latches a test configuration on a start pulse and seeds the MISR. It then runs the pattern source and the MISR for a programmed number of patterns, compensating for circuit-under-test latency. Finally it compares the MISR signature against a golden value and reports pass/fail. It sits between the test-access registers and the pattern-generator/MISR pair.

---
 rtl/misr_bist_ctrl.sv | 173 +++++++++++++++++
 tb/tb_misr_bist_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_bist_ctrl.sv
// misr_bist_ctrl: BIST sequencer for a SIG_W-bit MISR and its pattern generator.
// Latches a test config on start, applies num_pat patterns, drains CUT latency, checks signature.
module misr_bist_ctrl #(
  parameter int unsigned SIG_W = 10,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [SIG_W-1:0] cfg_poly,
  input  logic [SIG_W-1:0] cfg_seed,
  input  logic [SIG_W-1:0] golden,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             misr_rst,
  output logic             misr_en,
  output logic [SIG_W-1:0] misr_poly,
  output logic [SIG_W-1:0] misr_seed,
  output logic             pat_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig_out
);

  localparam int unsigned      DlyW   = (LAT > 0) ? LAT : 1;
  localparam logic [CNT_W-1:0] LatCnt = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StFlush,
    StCmp,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_pat_q;
  logic [SIG_W-1:0] poly_q, seed_q, golden_q;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             pat_en_q, pat_en_d;
  logic             misr_rst_q, misr_rst_d;
  logic             pass_q, pass_d;
  logic [DlyW-1:0]  dly_q, dly_d;
  logic             latch;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_en_d   = 1'b0;
    misr_rst_d = 1'b0;
    pass_d     = pass_q;
    sig_d      = sig_q;
    latch      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          latch      = 1'b1;
          misr_rst_d = 1'b1;
          pass_d     = 1'b0;
          state_d    = StInit;
        end
      end
      StInit: begin
        cnt_d = num_pat_q;
        if (num_pat_q != '0) begin
          state_d  = StRun;
          pat_en_d = 1'b1;
        end else if (LAT != 0) begin
          // Zero patterns still wait out the pipeline so latency stays num_pat+LAT+3.
          state_d = StFlush;
          cnt_d   = LatCnt;
        end else begin
          state_d = StCmp;
        end
      end
      StRun: begin
        cnt_d = cnt_q - One;
        if (cnt_q == One) begin
          if (LAT != 0) begin
            state_d = StFlush;
            cnt_d   = LatCnt;
          end else begin
            state_d = StCmp;
          end
        end else begin
          pat_en_d = 1'b1;
        end
      end
      StFlush: begin
        cnt_d = cnt_q - One;
        if (cnt_q == One) begin
          state_d = StCmp;
        end
      end
      StCmp: begin
        sig_d   = misr_sig;
        pass_d  = (misr_sig == golden_q);
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d    = StIdle;
      pat_en_d   = 1'b0;
      misr_rst_d = 1'b0;
      pass_d     = 1'b0;
      latch      = 1'b0;
    end
  end

  // Delay line models the CUT pipeline: misr_en follows pat_en by LAT cycles.
  always_comb begin
    dly_d = '0;
    if (!abort) begin
      dly_d = (dly_q << 1) | DlyW'(pat_en_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      num_pat_q  <= '0;
      poly_q     <= '0;
      seed_q     <= '0;
      golden_q   <= '0;
      sig_q      <= '0;
      pat_en_q   <= 1'b0;
      misr_rst_q <= 1'b0;
      pass_q     <= 1'b0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sig_q      <= sig_d;
      pat_en_q   <= pat_en_d;
      misr_rst_q <= misr_rst_d;
      pass_q     <= pass_d;
      dly_q      <= dly_d;
      if (latch) begin
        num_pat_q <= num_pat;
        poly_q    <= cfg_poly;
        seed_q    <= cfg_seed;
        golden_q  <= golden;
      end
    end
  end

  if (LAT == 0) begin : g_no_lat
    assign misr_en = pat_en_q;
  end else begin : g_lat
    assign misr_en = dly_q[DlyW-1];
  end

  assign misr_rst  = misr_rst_q;
  assign misr_poly = poly_q;
  assign misr_seed = seed_q;
  assign pat_en    = pat_en_q;
  assign busy      = (state_q == StInit) || (state_q == StRun) ||
                     (state_q == StFlush) || (state_q == StCmp);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign sig_out   = sig_q;

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Bench for misr_bist_ctrl: a behavioural MISR/CUT environment plus a loop-based signature model;
// event timing is logged per cycle and compared with the start-relative schedule.
module tb_misr_bist_ctrl;

  localparam int unsigned SIG_W = 10;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LAT   = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_pat;
  logic [SIG_W-1:0] cfg_poly, cfg_seed, golden, misr_sig;
  logic             misr_rst, misr_en, pat_en, busy, done, pass;
  logic [SIG_W-1:0] misr_poly, misr_seed, sig_out;

  misr_bist_ctrl #(
    .SIG_W(SIG_W),
    .CNT_W(CNT_W),
    .LAT  (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .num_pat  (num_pat),
    .cfg_poly (cfg_poly),
    .cfg_seed (cfg_seed),
    .golden   (golden),
    .misr_sig (misr_sig),
    .misr_rst (misr_rst),
    .misr_en  (misr_en),
    .misr_poly(misr_poly),
    .misr_seed(misr_seed),
    .pat_en   (pat_en),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .sig_out  (sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CUT responses and the MISR itself live in the environment.
  logic [SIG_W-1:0] resp [256];
  logic [SIG_W-1:0] env_q = '0;
  int               resp_idx = 0;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, p, d);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? p : '0) ^ d;
  endfunction

  always @(posedge clk) begin
    if (misr_rst) begin
      env_q    <= misr_seed;
      resp_idx <= 0;
    end else if (misr_en) begin
      env_q    <= misr_step(env_q, misr_poly, resp[resp_idx % 256]);
      resp_idx <= resp_idx + 1;
    end
  end
  assign misr_sig = env_q;

  function automatic logic [SIG_W-1:0] model_sig(input logic [SIG_W-1:0] seed, poly,
                                                 input int n);
    logic [SIG_W-1:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = misr_step(s, poly, resp[i]);
    return s;
  endfunction

  // Cycle stamps of every output event.
  int pat_q[$];
  int men_q[$];
  int rst_q[$];
  always @(negedge clk) begin
    if (pat_en) pat_q.push_back(cyc);
    if (misr_en) men_q.push_back(cyc);
    if (misr_rst) rst_q.push_back(cyc);
  end

  int               t0, exp_n, pb, mb, rb;
  logic [SIG_W-1:0] exp_sig, exp_poly, exp_seed;
  bit               exp_pass;

  task automatic launch(input int n, input logic [SIG_W-1:0] poly, seed, gmask);
    @(negedge clk);
    exp_n    = n;
    exp_poly = poly;
    exp_seed = seed;
    exp_sig  = model_sig(seed, poly, n);
    exp_pass = (gmask == '0);
    num_pat  = CNT_W'(n);
    cfg_poly = poly;
    cfg_seed = seed;
    golden   = exp_sig ^ gmask;
    start    = 1'b1;
    t0       = cyc;
    pb       = pat_q.size();
    mb       = men_q.size();
    rb       = rst_q.size();
    @(negedge clk);
    start = 1'b0;
    check_eq("init_busy", busy, 1);
    check_eq("init_done", done, 0);
    check_eq("init_pass", pass, 0);
  endtask

  task automatic finish_run();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < exp_n + int'(LAT) + 10; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("done_seen", seen, 1);
    check_eq("done_cyc", cyc - t0, exp_n + int'(LAT) + 3);
    check_eq("pat_cnt", pat_q.size() - pb, exp_n);
    check_eq("men_cnt", men_q.size() - mb, exp_n);
    check_eq("rst_cnt", rst_q.size() - rb, 1);
    if (rst_q.size() > rb) check_eq("rst_cyc", rst_q[rb] - t0, 1);
    if (exp_n > 0 && pat_q.size() > pb && men_q.size() > mb) begin
      check_eq("pat_first", pat_q[pb] - t0, 2);
      check_eq("pat_last", pat_q[$] - t0, exp_n + 1);
      check_eq("men_first", men_q[mb] - t0, 2 + int'(LAT));
      check_eq("men_last", men_q[$] - t0, exp_n + 1 + int'(LAT));
    end
    check_eq("pass", pass, exp_pass);
    check_eq("sig_out", sig_out, exp_sig);
    check_eq("misr_poly", misr_poly, exp_poly);
    check_eq("misr_seed", misr_seed, exp_seed);
    check_eq("busy_done", busy, 0);
  endtask

  task automatic check_idle(input string pfx);
    check_eq({pfx, "_pat_en"}, pat_en, 0);
    check_eq({pfx, "_misr_en"}, misr_en, 0);
    check_eq({pfx, "_misr_rst"}, misr_rst, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_pass"}, pass, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [SIG_W-1:0] p0, s0, gm;
  int               nr;

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    num_pat  = '0;
    cfg_poly = '0;
    cfg_seed = '0;
    golden   = '0;
    for (int i = 0; i < 256; i++) resp[i] = SIG_W'($urandom);

    repeat (2) @(negedge clk);
    check_idle("rst0");
    check_eq("rst0_sig_out", sig_out, 0);
    check_eq("rst0_poly", misr_poly, 0);
    check_eq("rst0_seed", misr_seed, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal, then identical config with a corrupted golden.
    p0 = SIG_W'($urandom) | 10'h204;
    s0 = SIG_W'($urandom);
    launch(5, p0, s0, '0);
    finish_run();
    launch(5, p0, s0, 10'h001);
    finish_run();

    // Zero patterns: signature is just the seed.
    launch(0, p0, 10'h2A5, '0);
    finish_run();

    // Abort after the third pattern, then a full rerun.
    launch(10, p0, s0, '0);
    repeat (3) @(negedge clk);
    check_eq("abort_pre_pat_en", pat_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort");
    check_eq("abort_pat_cnt", pat_q.size() - pb, 3);
    repeat (3) @(negedge clk);
    check_idle("abort_later");
    launch(10, p0, s0, '0);
    finish_run();

    // Start during RUN is ignored even with different inputs.
    launch(8, p0 ^ 10'h011, s0, '0);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    num_pat  = CNT_W'(2);
    cfg_poly = SIG_W'($urandom);
    cfg_seed = SIG_W'($urandom);
    golden   = SIG_W'($urandom);
    @(negedge clk);
    start = 1'b0;
    finish_run();
    // Restart straight from DONE.
    launch(1, p0, s0 ^ 10'h3C3, '0);
    finish_run();

    for (int r = 0; r < 6; r++) begin
      nr = $urandom_range(0, 30);
      gm = ($urandom_range(0, 1) == 0) ? '0 : SIG_W'($urandom_range(1, 1023));
      launch(nr, SIG_W'($urandom) | 10'h200, SIG_W'($urandom), gm);
      finish_run();
    end

    // Asynchronous reset mid-run.
    launch(20, p0, s0, '0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_idle("rstmid");
    check_eq("rstmid_sig_out", sig_out, 0);
    check_eq("rstmid_poly", misr_poly, 0);
    check_eq("rstmid_seed", misr_seed, 0);
    @(negedge clk);
    rst = 1'b1;
    pb  = pat_q.size();
    repeat (6) @(negedge clk);
    check_eq("rstmid_no_pat", pat_q.size() - pb, 0);
    check_eq("rstmid_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
